// File: rtl/aes_regs_pkg.sv
// Shared definitions for the AES Avalon-MM register file: word addresses,
// the handshake state encoding, the 128-bit block type and the byte-lane merge.
package aes_regs_pkg;

    localparam logic [3:0] ADDR_KEY0    = 4'd0;
    localparam logic [3:0] ADDR_KEY1    = 4'd1;
    localparam logic [3:0] ADDR_KEY2    = 4'd2;
    localparam logic [3:0] ADDR_KEY3    = 4'd3;
    localparam logic [3:0] ADDR_MSG0    = 4'd4;
    localparam logic [3:0] ADDR_MSG1    = 4'd5;
    localparam logic [3:0] ADDR_MSG2    = 4'd6;
    localparam logic [3:0] ADDR_MSG3    = 4'd7;
    localparam logic [3:0] ADDR_DEC0    = 4'd8;
    localparam logic [3:0] ADDR_DEC1    = 4'd9;
    localparam logic [3:0] ADDR_DEC2    = 4'd10;
    localparam logic [3:0] ADDR_DEC3    = 4'd11;
    localparam logic [3:0] ADDR_SCRATCH = 4'd12;
    localparam logic [3:0] ADDR_AUX     = 4'd13;
    localparam logic [3:0] ADDR_START   = 4'd14;
    localparam logic [3:0] ADDR_DONE    = 4'd15;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_reg_state_t;

    // Merge new write data into an old word, one byte lane per enable bit.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/aes_avalon_regs_if.sv
// Avalon-MM slave bus bundle between the Nios II interconnect and the AES register file.
interface aes_avalon_regs_if;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [3:0]  avs_address;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport slave (
        input  avs_chipselect, avs_read, avs_write, avs_address,
               avs_byteenable, avs_writedata,
        output avs_readdata
    );

    modport master (
        output avs_chipselect, avs_read, avs_write, avs_address,
               avs_byteenable, avs_writedata,
        input  avs_readdata
    );
endinterface

// File: rtl/aes_be_reg.sv
// 32-bit software register with per-byte write enables and async active-low reset.
module aes_be_reg
    import aes_regs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    // Next value: merge enabled byte lanes on a write, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (we) word_d = apply_be(word_q, wdata, be);
    end

    // Word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    assign q = word_q;

endmodule

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file fronting the AES decryption core: key/message
// storage, start/done handshake, result capture and hex-display export.
// Build option: define AES_AVALON_CYCLE_CNT_EN to turn word 13 into a
// read-only count of cycles spent in RUN; otherwise word 13 is a scratch word.
module aes_avalon_regs
    import aes_regs_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    aes_avalon_regs_if.slave   avs,
    output aes_block_t         aes_key,
    output aes_block_t         aes_msg_enc,
    output logic               aes_start,
    input  logic               aes_done,
    input  aes_block_t         aes_msg_dec,
    output logic [31:0]        export_data
);

    logic           wr_en;
    logic           rd_en;
    logic           start_wr;
    logic           start_val;
    logic           capture;
    logic           done;
    logic [31:0]    kw [0:7];
    logic [31:0]    scratch_word;
    logic [31:0]    aux_word;

    aes_reg_state_t state_q, state_d;
    aes_block_t     dec_q, dec_d;
    logic           start_bit_q, start_bit_d;
    logic [31:0]    rdata_q, rdata_d;

    assign wr_en     = avs.avs_chipselect & avs.avs_write;
    assign rd_en     = avs.avs_chipselect & avs.avs_read;
    assign start_wr  = wr_en && (avs.avs_address == ADDR_START) && avs.avs_byteenable[0];
    assign start_val = avs.avs_writedata[0];

    // Key and encrypted-message words; frozen while the core is running.
    for (genvar i = 0; i < 8; i++) begin : g_kw
        aes_be_reg u_reg (
            .clk   (clk),
            .rst_n (reset_n),
            .we    (wr_en && (avs.avs_address == 4'(i)) && (state_q != RUN)),
            .be    (avs.avs_byteenable),
            .wdata (avs.avs_writedata),
            .q     (kw[i])
        );
    end

    aes_be_reg u_scratch (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (wr_en && (avs.avs_address == ADDR_SCRATCH)),
        .be    (avs.avs_byteenable),
        .wdata (avs.avs_writedata),
        .q     (scratch_word)
    );

`ifdef AES_AVALON_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    // RUN-cycle counter: restart on entry to RUN, count while in RUN, saturate.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q != RUN) && (state_d == RUN)) cyc_cnt_d = '0;
        else if ((state_q == RUN) && (cyc_cnt_q != 32'hFFFF_FFFF)) cyc_cnt_d = cyc_cnt_q + 32'd1;
    end

    // Counter storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_cnt_q <= '0;
        else          cyc_cnt_q <= cyc_cnt_d;
    end

    assign aux_word = cyc_cnt_q;
`else
    aes_be_reg u_aux (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (wr_en && (avs.avs_address == ADDR_AUX)),
        .be    (avs.avs_byteenable),
        .wdata (avs.avs_writedata),
        .q     (aux_word)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; an abort write takes priority over a same-cycle done.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (start_wr && start_val) state_d = RUN;
            RUN: begin
                if (start_wr && !start_val) begin
                    state_d = IDLE;
                end else if (aes_done) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            DONE: if (start_wr) state_d = start_val ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register, so reset drops aes_start at once.
    always_comb begin
        aes_start = (state_q == RUN);
        done      = (state_q == DONE);
    end

    // Stored START bit and decrypted-result capture.
    always_comb begin
        start_bit_d = start_bit_q;
        dec_d       = dec_q;
        if (start_wr) start_bit_d = start_val;
        if (capture)  dec_d       = aes_msg_dec;
    end

    // START bit and result storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_bit_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            start_bit_q <= start_bit_d;
            dec_q       <= dec_d;
        end
    end

    // Read mux: load addressed word on a read strobe, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (avs.avs_address)
                ADDR_KEY0:    rdata_d = kw[0];
                ADDR_KEY1:    rdata_d = kw[1];
                ADDR_KEY2:    rdata_d = kw[2];
                ADDR_KEY3:    rdata_d = kw[3];
                ADDR_MSG0:    rdata_d = kw[4];
                ADDR_MSG1:    rdata_d = kw[5];
                ADDR_MSG2:    rdata_d = kw[6];
                ADDR_MSG3:    rdata_d = kw[7];
                ADDR_DEC0:    rdata_d = dec_q[127:96];
                ADDR_DEC1:    rdata_d = dec_q[95:64];
                ADDR_DEC2:    rdata_d = dec_q[63:32];
                ADDR_DEC3:    rdata_d = dec_q[31:0];
                ADDR_SCRATCH: rdata_d = scratch_word;
                ADDR_AUX:     rdata_d = aux_word;
                ADDR_START:   rdata_d = {31'b0, start_bit_q};
                ADDR_DONE:    rdata_d = {31'b0, done};
                default:      rdata_d = '0;
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign avs.avs_readdata = rdata_q;
    assign aes_key          = {kw[0], kw[1], kw[2], kw[3]};
    assign aes_msg_enc      = {kw[4], kw[5], kw[6], kw[7]};
    assign export_data      = {kw[0][31:16], kw[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Directed testbench for aes_avalon_regs: bus access, handshake, abort,
// cycle counter / scratch word 13, and asynchronous reset during RUN.
module tb_aes_avalon_regs;
    import aes_regs_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    aes_block_t aes_key;
    aes_block_t aes_msg_enc;
    logic       aes_start;
    logic       aes_done;
    aes_block_t aes_msg_dec;
    logic [31:0] export_data;
    logic [31:0] rd;

    int checks   = 0;
    int failures = 0;

    aes_avalon_regs_if bus ();

    aes_avalon_regs dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avs         (bus.slave),
        .aes_key     (aes_key),
        .aes_msg_enc (aes_msg_enc),
        .aes_start   (aes_start),
        .aes_done    (aes_done),
        .aes_msg_dec (aes_msg_dec),
        .export_data (export_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        bus.avs_byteenable = be;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_address    = a;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        d = bus.avs_readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n            = 1'b0;
        aes_done           = 1'b0;
        aes_msg_dec        = '0;
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = '0;
        bus.avs_byteenable = '0;
        bus.avs_writedata  = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 128'(aes_start), 128'd0);
        check("rst_export", 128'(export_data), 128'd0);
        check("rst_readdata", 128'(bus.avs_readdata), 128'd0);
        reset_n = 1'b1;

        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), rd);
            check($sformatf("rst_read_%0d", a), 128'(rd), 128'd0);
        end

        // Byte-enable writes and export mapping.
        bus_write(ADDR_KEY0, 32'hDEAD_BEEF, 4'b1111);
        bus_write(ADDR_KEY3, 32'h0123_4567, 4'b0011);
        check("export_after_wr", 128'(export_data), 128'hDEAD_4567);
        bus_read(ADDR_KEY3, rd);
        check("reg3_be", 128'(rd), 128'h0000_4567);
        check("key_out", aes_key, 128'hDEADBEEF_00000000_00000000_00004567);

        // Read and write same word in one cycle returns the old value.
        bus_write(ADDR_SCRATCH, 32'hAAAA_AAAA, 4'b1111);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_read       = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = ADDR_SCRATCH;
        bus.avs_writedata  = 32'h5555_5555;
        bus.avs_byteenable = 4'b1111;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        check("rw_same_old", 128'(bus.avs_readdata), 128'hAAAA_AAAA);
        bus_read(ADDR_SCRATCH, rd);
        check("rw_same_new", 128'(rd), 128'h5555_5555);

        // aes_done high in IDLE has no effect.
        aes_msg_dec = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
        aes_done = 1'b1;
        repeat (3) @(negedge clk);
        aes_done = 1'b0;
        bus_read(ADDR_DEC0, rd);
        check("idle_done_ignored", 128'(rd), 128'd0);
        bus_read(ADDR_DONE, rd);
        check("idle_done_flag", 128'(rd), 128'd0);

        // Abort wins over a same-cycle done.
        bus_write(ADDR_START, 32'h1, 4'b0001);
        check("abort_run_start", 128'(aes_start), 128'd1);
        @(negedge clk);
        bus.avs_chipselect = 1'b1;
        bus.avs_write      = 1'b1;
        bus.avs_address    = ADDR_START;
        bus.avs_writedata  = 32'h0;
        bus.avs_byteenable = 4'b0001;
        aes_done           = 1'b1;
        @(negedge clk);
        bus.avs_chipselect = 1'b0;
        bus.avs_write      = 1'b0;
        aes_done           = 1'b0;
        check("abort_start_low", 128'(aes_start), 128'd0);
        bus_read(ADDR_DEC0, rd);
        check("abort_reg8", 128'(rd), 128'd0);
        bus_read(ADDR_DEC3, rd);
        check("abort_reg11", 128'(rd), 128'd0);
        bus_read(ADDR_DONE, rd);
        check("abort_done", 128'(rd), 128'd0);

        // Full run with capture.
        bus_write(ADDR_KEY1, 32'h1111_1111, 4'b1111);
        bus_write(ADDR_KEY2, 32'h2222_2222, 4'b1111);
        bus_write(ADDR_MSG0, 32'h4444_4444, 4'b1111);
        bus_write(ADDR_MSG1, 32'h5555_5555, 4'b1111);
        bus_write(ADDR_MSG2, 32'h6666_6666, 4'b1111);
        bus_write(ADDR_MSG3, 32'h7777_7777, 4'b1111);
        check("msg_out", aes_msg_enc, 128'h44444444_55555555_66666666_77777777);
        bus_write(ADDR_START, 32'h1, 4'b0001);
        check("run_start", 128'(aes_start), 128'd1);
        bus_write(ADDR_KEY1, 32'hFFFF_FFFF, 4'b1111);
        bus_read(ADDR_KEY1, rd);
        check("run_key_frozen", 128'(rd), 128'h1111_1111);
        aes_msg_dec = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        @(negedge clk);
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        check("done_start_low", 128'(aes_start), 128'd0);
        bus_read(ADDR_DONE, rd);
        check("done_flag", 128'(rd), 128'd1);
        bus_read(ADDR_DEC0, rd);
        check("cap_reg8", 128'(rd), 128'h0011_2233);
        bus_read(ADDR_DEC1, rd);
        check("cap_reg9", 128'(rd), 128'h4455_6677);
        bus_read(ADDR_DEC3, rd);
        check("cap_reg11", 128'(rd), 128'hCCDD_EEFF);
        bus_read(ADDR_START, rd);
        check("start_bit_kept", 128'(rd), 128'd1);

        // Restart from DONE, hold RUN for 37 cycles including the done edge.
        bus_write(ADDR_START, 32'h1, 4'b0001);
        check("restart_start", 128'(aes_start), 128'd1);
        repeat (36) @(negedge clk);
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        check("restart_done_start", 128'(aes_start), 128'd0);
`ifdef AES_AVALON_CYCLE_CNT_EN
        bus_read(ADDR_AUX, rd);
        check("cyc_cnt_37", 128'(rd), 128'd37);
        bus_write(ADDR_AUX, 32'hCAFE_F00D, 4'b1111);
        bus_read(ADDR_AUX, rd);
        check("cyc_cnt_hold_ro", 128'(rd), 128'd37);
`else
        bus_write(ADDR_AUX, 32'hCAFE_F00D, 4'b1111);
        bus_read(ADDR_AUX, rd);
        check("reg13_scratch", 128'(rd), 128'hCAFE_F00D);
`endif

        // Asynchronous reset during RUN.
        bus_write(ADDR_START, 32'h1, 4'b0001);
        check("pre_reset_start", 128'(aes_start), 128'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_start", 128'(aes_start), 128'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(ADDR_START, rd);
        check("post_reset_start_reg", 128'(rd), 128'd0);
        bus_read(ADDR_KEY0, rd);
        check("post_reset_key0", 128'(rd), 128'd0);
        bus_read(ADDR_KEY1, rd);
        check("post_reset_key1", 128'(rd), 128'd0);
        check("post_reset_export", 128'(export_data), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_avalon_regs.md
# aes_avalon_regs

Avalon-MM slave register file that sits between the Nios II bus and the AES decryption core inside the lab 9 SoC. It holds the 128-bit key and encrypted message written by software, runs a start/done handshake with the core, captures the 128-bit decrypted result, and drives the 32-bit hex-display export (`aes_export_export_data` at the system top).

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock. One clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `avs_chipselect` in 1: slave select.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_address` in 4: word address 0–15.
- `avs_byteenable` in 4: write byte lanes.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: registered read data.
- `aes_key` out 128: {reg0, reg1, reg2, reg3}, with reg0 as the MSW.
- `aes_msg_enc` out 128: {reg4 … reg7}.
- `aes_start` out 1: run request to the core (level).
- `aes_done` in 1: core completion (level).
- `aes_msg_dec` in 128: core result.
- `export_data` out 32: {reg0[31:16], reg3[15:0]}.

## Operation
- Address map:
  - 0–3: key, RW.
  - 4–7: encrypted message, RW.
  - 8–11: decrypted message, RO; the core writes it.
  - 12: scratch, RW.
  - 13: see Configuration.
  - 14: START, RW; only bit0 is stored, other bits read 0.
  - 15: DONE, RO, {31'b0, done}.
- Write: a write occurs when `avs_chipselect & avs_write`. Each byte lane is updated only where its `avs_byteenable` bit is 1. Writes to RO addresses are ignored.
- Read: a read occurs when `avs_chipselect & avs_read`. `avs_readdata` loads the addressed value. Otherwise `avs_readdata` holds its previous value.
- FSM states:
  - IDLE:
    - A write to reg14 with byte0 enabled and bit0=1 → RUN.
    - `aes_done` is ignored.
  - RUN:
    - `aes_start`=1.
    - Writes to regs 0–7 are ignored, so key and message stay stable.
    - `aes_done`=1 → capture `aes_msg_dec` into regs 8–11 (reg8 = bits [127:96]), set done=1 → DONE.
    - A write of START bit0=0 → abort → IDLE. Nothing is captured and done stays 0.
  - DONE:
    - `aes_start`=0.
    - A write of START bit0=0 → clear done → IDLE.
    - A write of START bit0=1 → clear done → RUN (restart).
- Reset: all regs 0, `avs_readdata`=0, `export_data`=0, `aes_start`=0, done=0, state IDLE. Reset mid-RUN aborts silently, and the core sees `aes_start` fall asynchronously.

## Timing
- Read latency is 1: data is valid on the edge after the read strobe. A read in the same cycle as a write to the same address returns the old value.
- Written value is visible on the outputs (`aes_key`, `export_data`) 1 cycle after the write edge.
- START write edge → `aes_start`=1 on the next cycle.
- `aes_done` sampled high in RUN at edge N:
  - regs 8–11 and DONE valid after N.
  - `aes_start`=0 after N.
  - A DONE read issued at N+1 returns 1.
- Simultaneous abort write and `aes_done` in RUN: the abort wins. Nothing is captured and the state goes to IDLE.
- `aes_done` held high through IDLE/DONE: no effect. A capture only occurs on RUN.

## Configuration
- `AES_AVALON_CYCLE_CNT_EN` defined:
  - Reg13 is an RO 32-bit counter of cycles spent in RUN.
  - It clears on the IDLE/DONE→RUN transition, increments each RUN cycle, and saturates at 0xFFFFFFFF.
  - It holds its value in DONE/IDLE.
- Undefined: reg13 is an RW scratch register, the same as reg12.

## Structure
- Package `aes_regs_pkg` holds:
  - address localparams (`ADDR_KEY0` … `ADDR_DONE`),
  - the state enum `aes_reg_state_t` {IDLE, RUN, DONE},
  - the 128-bit block typedef.
- Sub-module `aes_be_reg`: a 32-bit register with byte enables and asynchronous active-low reset, instantiated for each RW word.

## Test plan
- Reset, then read all 16 addresses → 0. `export_data`=0, `aes_start`=0.
- Write reg0=0xDEADBEEF with byteenable 4'b1111, then reg3=0x01234567 with byteenable 4'b0011 → reg3 reads 0x00004567 and `export_data`=0xDEAD4567.
- Load key/msg, write START=1 → `aes_start`=1 next cycle. A write of 0xFFFFFFFF to reg1 in RUN is ignored. The model asserts `aes_done` with `aes_msg_dec`=0x00112233_44556677_8899AABB_CCDDEEFF → reg8=0x00112233, reg11=0xCCDDEEFF, DONE=1, `aes_start`=0.
- In RUN, write START=0 in the same cycle `aes_done`=1 → state IDLE, regs 8–11 unchanged (0), DONE=0.
- With `AES_AVALON_CYCLE_CNT_EN`, hold RUN for 37 cycles then `aes_done` → reg13=37. Without the macro, reg13 read-back returns the written 0xCAFEF00D.
- Assert `reset_n` low mid-RUN → `aes_start` drops with no clock edge. After release, START reads 0 and the key regs read 0.
